oki_exp_responder: RTL and testbench

- FPGA-side responder for the OKI 4-bit I/O-expander bus (MCU P2[3:0] plus PROG_N strobe), equivalent to an 82C43-style expander.
- Decodes {op[1:0], addr[1:0]} commands and serves four logical 4-bit ports (addr 0..3 = P4..P7).
- Reads return fabric-supplied nibbles; WRITE/OR/AND update output registers used as mailbox data and control flags.
- Sits in top between the level-translator pins (p2, p2_buf_oe, p2_buf_dir) and the UART/mailbox logic.

---
 rtl/oki_exp_pkg.sv | 40 ++++
 rtl/oki_exp_responder_capture.sv | 48 ++++
 rtl/oki_exp_responder.sv | 144 ++++++++++++++
 tb/tb_oki_exp_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/oki_exp_pkg.sv
// Shared types and bus timing minimums for the OKI 4-bit I/O-expander responder.
`timescale 1ns/1ps
package oki_exp_pkg;

   typedef enum logic [1:0] {
      READ   = 2'b00,
      WRITE  = 2'b01,
      OP_OR  = 2'b10,
      OP_AND = 2'b11
   } bus_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DECODE,
      ST_DRIVE,
      ST_WDATA,
      ST_DONE
   } exp_state_t;

   // MCU-guaranteed bus timing minimums in ns
   localparam int T_CMD_SETUP_NS  = 50;
   localparam int T_CMD_HOLD_NS   = 60;
   localparam int T_PROG_LOW_NS   = 700;
   localparam int T_DATA_SETUP_NS = 200;
   localparam int T_DATA_HOLD_NS  = 20;

   function automatic logic [3:0] apply_op(input bus_op_t op, input logic [3:0] cur,
                                           input logic [3:0] dat);
      logic [3:0] res;
      res = cur;
      case (op)
         WRITE:   res = dat;
         OP_OR:   res = cur | dat;
         OP_AND:  res = cur & dat;
         default: res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/oki_exp_responder_capture.sv
// prog_n-domain capture of the command and write nibbles, plus the prog_n synchronizer
// and edge detector that hand transaction boundaries to the clk domain.
`timescale 1ns/1ps
module oki_prog_capture
   import oki_exp_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       prog_n,
   input  logic [3:0] p2_in,
   output logic [3:0] cmd_raw,
   output logic [3:0] data_raw,
   output logic       fall_p,
   output logic       rise_p
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // The command window is shorter than a clk period, so prog_n itself is the clock.
   always_ff @(negedge prog_n or negedge rst_n) begin
      if (!rst_n) cmd_raw <= '0;
      else        cmd_raw <= p2_in;
   end

   always_ff @(posedge prog_n or negedge rst_n) begin
      if (!rst_n) data_raw <= '0;
      else        data_raw <= p2_in;
   end

   // Reset to "low" so a prog_n already low at reset release never produces a fall;
   // the FSM stays disarmed until prog_n has been seen high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], prog_n};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign fall_p = prev_q & ~sync_q[SYNC_STAGES-1];
   assign rise_p = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/oki_exp_responder.sv
// 82C43-style 4-bit I/O-expander responder serving ports P4..P7 to the MCU.
// Optional macro OKI_EXP_READBACK_EN: reads of an output-mode port return port_out.
`timescale 1ns/1ps
module oki_exp_responder
   import oki_exp_pkg::*;
#(
   parameter logic [3:0] PORT_RESET  = 4'hF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        prog_n,
   inout  wire  [3:0]  p2,
   output logic        p2_buf_oe,
   output logic        p2_buf_dir,
   input  logic [15:0] port_in,
   output logic [15:0] port_out,
   output logic [3:0]  port_is_out,
   output logic        wr_stb,
   output logic        rd_stb,
   output logic [1:0]  stb_addr,
   output logic [1:0]  stb_op
);

   exp_state_t state_q, state_d;
   bus_op_t    op_q;
   logic [1:0] addr_q;
   logic [3:0] rd_data_q, rd_sel;
   logic [3:0] cmd_raw, data_raw;
   logic       fall_p, rise_p;
   logic       drive_q, drive_en;
   logic       ld_cmd, set_drv, clr_drv, do_wr, do_rd;

   oki_prog_capture #(.SYNC_STAGES(SYNC_STAGES)) u_capture (
      .clk      (clk),
      .rst_n    (rst_n),
      .prog_n   (prog_n),
      .p2_in    (p2),
      .cmd_raw  (cmd_raw),
      .data_raw (data_raw),
      .fall_p   (fall_p),
      .rise_p   (rise_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ld_cmd  = 1'b0;
      set_drv = 1'b0;
      clr_drv = 1'b0;
      do_wr   = 1'b0;
      do_rd   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (fall_p) begin
               ld_cmd  = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // A rise already here means a runt strobe: drop it silently.
            if (rise_p)              state_d = ST_IDLE;
            else if (op_q == READ) begin
               set_drv = 1'b1;
               state_d = ST_DRIVE;
            end else                 state_d = ST_WDATA;
         end
         ST_DRIVE: begin
            if (rise_p) begin
               clr_drv = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WDATA: begin
            if (rise_p) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (op_q == READ) do_rd = 1'b1;
            else              do_wr = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rd_sel = port_in[{addr_q, 2'b00} +: 4];
`ifdef OKI_EXP_READBACK_EN
      if (port_is_out[addr_q]) rd_sel = port_out[{addr_q, 2'b00} +: 4];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= READ;
         addr_q      <= '0;
         drive_q     <= 1'b0;
         port_out    <= {4{PORT_RESET}};
         port_is_out <= '0;
         wr_stb      <= 1'b0;
         rd_stb      <= 1'b0;
         stb_addr    <= '0;
         stb_op      <= '0;
         p2_buf_oe   <= 1'b0;
      end else begin
         p2_buf_oe <= 1'b1;
         wr_stb    <= do_wr;
         rd_stb    <= do_rd;
         if (ld_cmd) begin
            op_q   <= bus_op_t'(cmd_raw[3:2]);
            addr_q <= cmd_raw[1:0];
         end
         if (set_drv) begin
            drive_q              <= 1'b1;
            port_is_out[addr_q]  <= 1'b0;
         end else if (clr_drv) begin
            drive_q <= 1'b0;
         end
         if (do_wr) begin
            port_out[{addr_q, 2'b00} +: 4] <= apply_op(op_q, port_out[{addr_q, 2'b00} +: 4], data_raw);
            port_is_out[addr_q]            <= 1'b1;
         end
         if (do_wr | do_rd) begin
            stb_addr <= addr_q;
            stb_op   <= op_q;
         end
      end
   end

   // Read data is frozen at decode so port_in movement during DRIVE is invisible.
   always_ff @(posedge clk) begin
      if (set_drv) rd_data_q <= rd_sel;
   end

   // Raw prog_n gate releases the bus the instant the MCU ends the strobe.
   assign drive_en   = drive_q & ~prog_n;
   assign p2         = drive_en ? rd_data_q : 4'bzzzz;
   assign p2_buf_dir = drive_en;

endmodule

// File: tb/tb_oki_exp_responder.sv
// Directed bench for oki_exp_responder: MCU-side bus tasks at minimum timing.
`timescale 1ns/1ps
module tb_oki_exp_responder;
   import oki_exp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prog_n = 1'b1;
   logic [15:0] port_in = 16'h0000;
   tri   [3:0]  p2;
   logic        p2_buf_oe, p2_buf_dir;
   logic [15:0] port_out;
   logic [3:0]  port_is_out;
   logic        wr_stb, rd_stb;
   logic [1:0]  stb_addr, stb_op;

   logic        mcu_oe = 1'b0;
   logic [3:0]  mcu_dat = 4'h0;
   assign p2 = mcu_oe ? mcu_dat : 4'bzzzz;

   int n_checks = 0;
   int n_errors = 0;
   int wr_cnt = 0, rd_cnt = 0, dir_cnt = 0;
   logic [1:0] last_addr = 2'd0, last_op = 2'd0;

   oki_exp_responder #(.PORT_RESET(4'hF), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .prog_n      (prog_n),
      .p2          (p2),
      .p2_buf_oe   (p2_buf_oe),
      .p2_buf_dir  (p2_buf_dir),
      .port_in     (port_in),
      .port_out    (port_out),
      .port_is_out (port_is_out),
      .wr_stb      (wr_stb),
      .rd_stb      (rd_stb),
      .stb_addr    (stb_addr),
      .stb_op      (stb_op)
   );

   always #62.5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_stb) begin
         wr_cnt++;
         last_addr = stb_addr;
         last_op   = stb_op;
      end
      if (rd_stb) begin
         rd_cnt++;
         last_addr = stb_addr;
         last_op   = stb_op;
      end
      if (p2_buf_dir) dir_cnt++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mcu_read(input logic [1:0] addr, output logic [3:0] dat);
      logic dir_low, dir_rel;
      mcu_dat = {READ, addr};
      mcu_oe  = 1'b1;
      #(T_CMD_SETUP_NS) prog_n = 1'b0;
      #(T_CMD_HOLD_NS)  mcu_oe = 1'b0;
      #(760 - T_CMD_HOLD_NS);
      dat     = p2;
      dir_low = p2_buf_dir;
      #40 prog_n = 1'b1;
      #1 dir_rel = p2_buf_dir;
      check_val("rd_dir_during", {31'd0, dir_low}, 32'd1);
      check_val("rd_dir_release", {31'd0, dir_rel}, 32'd0);
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic mcu_write(input bus_op_t op, input logic [1:0] addr, input logic [3:0] data);
      mcu_dat = {op, addr};
      mcu_oe  = 1'b1;
      #(T_CMD_SETUP_NS) prog_n = 1'b0;
      #(T_CMD_HOLD_NS)  mcu_oe = 1'b0;
      #(T_PROG_LOW_NS - T_CMD_HOLD_NS - T_DATA_SETUP_NS);
      mcu_dat = data;
      mcu_oe  = 1'b1;
      #(T_DATA_SETUP_NS) prog_n = 1'b1;
      #(T_DATA_HOLD_NS)  mcu_oe = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] rd_val, lo_nib, hi_nib, exp_rb;
      int wr0, rd0, dir0;

      #100;
      check_val("rst_buf_oe", {31'd0, p2_buf_oe}, 32'd0);
      check_val("rst_buf_dir", {31'd0, p2_buf_dir}, 32'd0);
      check_val("rst_port_out", {16'd0, port_out}, 32'hFFFF);
      check_val("rst_port_is_out", {28'd0, port_is_out}, 32'd0);
      check_val("rst_strobes", {30'd0, wr_stb, rd_stb}, 32'd0);
      check_val("rst_stb_info", {28'd0, stb_addr, stb_op}, 32'd0);
      #30 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_val("buf_oe_after_rst", {31'd0, p2_buf_oe}, 32'd1);

      // Read port 2
      port_in = 16'h5600;
      mcu_read(2'd2, rd_val);
      check_val("read_p2_data", {28'd0, rd_val}, 32'h6);
      check_val("read_p2_rd_cnt", rd_cnt, 1);
      check_val("read_p2_addr", {30'd0, last_addr}, 32'd2);
      check_val("read_p2_op", {30'd0, last_op}, {30'd0, READ});

      // WRITE then AND on port 3
      mcu_write(WRITE, 2'd3, 4'hF);
      check_val("write_p3", {16'd0, port_out}, 32'hFFFF);
      check_val("write_wr_cnt", wr_cnt, 1);
      check_val("write_is_out", {28'd0, port_is_out}, 32'b1000);
      mcu_write(OP_AND, 2'd3, 4'b1101);
      check_val("and_p3", {16'd0, port_out}, 32'hDFFF);
      check_val("and_wr_cnt", wr_cnt, 2);
      check_val("and_op", {30'd0, last_op}, {30'd0, OP_AND});

      // OR then READ port 3
      mcu_write(OP_OR, 2'd3, 4'b0010);
      check_val("or_p3", {16'd0, port_out}, 32'hFFFF);
      check_val("or_wr_cnt", wr_cnt, 3);
`ifdef OKI_EXP_READBACK_EN
      exp_rb = 4'hF;
`else
      exp_rb = 4'h5;
`endif
      mcu_read(2'd3, rd_val);
      check_val("read_p3_data", {28'd0, rd_val}, {28'd0, exp_rb});
      check_val("read_p3_is_out", {28'd0, port_is_out}, 32'd0);
      check_val("read_p3_rd_cnt", rd_cnt, 2);

      // Nibble mailbox
      port_in = 16'h50AD;
      mcu_read(2'd0, lo_nib);
      check_val("mbox_addr0", {30'd0, last_addr}, 32'd0);
      mcu_read(2'd1, hi_nib);
      check_val("mbox_addr1", {30'd0, last_addr}, 32'd1);
      check_val("mbox_byte", {24'd0, hi_nib, lo_nib}, 32'hAD);
      check_val("mbox_rd_cnt", rd_cnt, 4);

      // Reset in the middle of a WRITE's PROG-low phase
      wr0 = wr_cnt;
      mcu_dat = {WRITE, 2'd0};
      mcu_oe  = 1'b1;
      #(T_CMD_SETUP_NS) prog_n = 1'b0;
      #(T_CMD_HOLD_NS)  mcu_oe = 1'b0;
      #240 rst_n = 1'b0;
      #10;
      check_val("midrst_buf_oe", {31'd0, p2_buf_oe}, 32'd0);
      #90 rst_n = 1'b1;
      #40 mcu_dat = 4'h3;
      mcu_oe = 1'b1;
      #(T_DATA_SETUP_NS) prog_n = 1'b1;
      #(T_DATA_HOLD_NS)  mcu_oe = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_val("midrst_no_wr", wr_cnt, wr0);
      check_val("midrst_port_out", {16'd0, port_out}, 32'hFFFF);
      check_val("midrst_is_out", {28'd0, port_is_out}, 32'd0);
      mcu_write(WRITE, 2'd1, 4'h2);
      check_val("postrst_port_out", {16'd0, port_out}, 32'hFF2F);
      check_val("postrst_wr_cnt", wr_cnt, wr0 + 1);
      check_val("postrst_addr", {30'd0, last_addr}, 32'd1);

      // 40 ns PROG_N glitch straddling a clk edge
      wr0  = wr_cnt;
      rd0  = rd_cnt;
      dir0 = dir_cnt;
      mcu_dat = {READ, 2'd0};
      mcu_oe  = 1'b1;
      @(negedge clk);
      #45 prog_n = 1'b0;
      #40 prog_n = 1'b1;
      #20 mcu_oe = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check_val("glitch_no_wr", wr_cnt, wr0);
      check_val("glitch_no_rd", rd_cnt, rd0);
      check_val("glitch_no_drive", dir_cnt, dir0);
      port_in = 16'h0090;
      mcu_read(2'd1, rd_val);
      check_val("post_glitch_read", {28'd0, rd_val}, 32'h9);
      check_val("post_glitch_rd_cnt", rd_cnt, rd0 + 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
